// File: rtl/mac_pkg.sv
// Shared types for the MAC sequencer: data width and FSM state encoding.
package mac_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_RUN     = 3'd2,
        S_WAIT    = 3'd3,
        S_CAPTURE = 3'd4,
        S_HOLD    = 3'd5
    } state_t;

endpackage

// File: rtl/mac_sequencer_if.sv
// Operand input and result output ports of the MAC sequencer.
interface mac_sequencer_if;
    import mac_pkg::*;

    // valid/ready: a transfer happens on a rising edge where both are high;
    // the source holds valid and data stable until that edge.
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;

    modport master (
        output in_valid, in_a, in_b, res_ready,
        input  in_ready, res_valid, res_data
    );

    modport slave (
        input  in_valid, in_a, in_b, res_ready,
        output in_ready, res_valid, res_data
    );

endinterface

// File: rtl/mac.sv
// 8x8 MAC stage: adds the high byte of each product into a 12-bit accumulator;
// out is accumulator[11:4]. Reset is synchronous.
module mac (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] out
);
    logic [15:0] prod;
    logic [11:0] acc_q, acc_d;

    assign prod  = a * b;
    assign acc_d = acc_q + 12'(prod >> 8);
    assign out   = acc_q[11:4];

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/mac_sequencer_operand_fifo.sv
// Synchronous operand FIFO; occupancy counter gives full/empty.
module operand_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Power-of-two depth lets the pointers wrap by plain overflow.
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mac_sequencer.sv
// Feeds LEN buffered operand pairs into the MAC after clearing it, then
// returns the captured MAC output on a valid/ready result port.
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int LEN   = 9,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    mac_sequencer_if.slave    bus,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    output logic              mac_en,
    output logic              mac_clr,
    input  logic [DATA_W-1:0] mac_out,
    output logic              busy,
    output state_t            state_o
);
    localparam int CW = $clog2(LEN + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(LEN - 1);

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]   mac_a_q, mac_a_d;
    logic [DATA_W-1:0]   mac_b_q, mac_b_d;
    logic                mac_en_q, mac_en_d;
    logic [DATA_W-1:0]   res_data_q, res_data_d;
    logic                res_valid_q, res_valid_d;

    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [2*DATA_W-1:0] fifo_dout;

    assign fifo_push = bus.in_valid & ~fifo_full;

    operand_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({bus.in_a, bus.in_b}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mac_a_d     = mac_a_q;
        mac_b_d     = mac_b_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        fifo_pop    = (state_q == S_RUN) & ~fifo_empty;
        mac_en_d    = fifo_pop;

        if (fifo_pop) begin
            mac_a_d = fifo_dout[2*DATA_W-1:DATA_W];
            mac_b_d = fifo_dout[DATA_W-1:0];
        end

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                // An empty FIFO here is just a bubble: no pop, no count.
                if (fifo_pop) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                res_data_d  = mac_out;
                res_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            mac_en_q    <= 1'b0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            mac_en_q    <= mac_en_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign bus.in_ready  = ~fifo_full;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign mac_a         = mac_a_q;
    assign mac_b         = mac_b_q;
    assign mac_en        = mac_en_q;
    assign mac_clr       = (state_q == S_CLEAR);
    assign busy          = (state_q != S_IDLE);
    assign state_o       = state_q;

endmodule
